men: RTL and testbench

- Memory-access (MEM) pipeline stage.
- Sits between the ex_men pipeline register and men_wb; its men_wdata/men_addr/men_wd outputs drive men_wb directly.
- Executes loads/stores over a req/ack data bus with variable wait states, and requests a pipeline stall while an access is outstanding.
- Formats load data (byte/half/word, sign/zero extend) and passes non-memory results straight through.

---
 rtl/men.sv | 255 +++++++++++++++++++++++++
 tb/tb_men.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/men.sv
// Memory-access pipeline stage: runs loads/stores over a req/ack data bus and formats load results.
// Optional build macro MEN_ALIGN_CHECK_EN traps misaligned half/word accesses instead of truncating the offset.
module men #(
  parameter int DBUS_AW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ex_wdata,
  input  logic [4:0]         ex_addr,
  input  logic               ex_wd,
  input  logic [3:0]         ex_memop,
  input  logic [31:0]        ex_mem_addr,
  input  logic [31:0]        ex_store_data,
  output logic               dbus_req,
  output logic               dbus_we,
  output logic [DBUS_AW-1:0] dbus_addr,
  output logic [3:0]         dbus_be,
  output logic [31:0]        dbus_wdata,
  input  logic               dbus_ack,
  input  logic [31:0]        dbus_rdata,
  output logic [31:0]        men_wdata,
  output logic [4:0]         men_addr,
  output logic               men_wd,
  output logic               stallreq,
  output logic               men_excp_align
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic                 is_load_s, is_store_s;
  logic [1:0]           size_s;
  logic [1:0]           off_s;
  logic                 misalign_s;
  logic [3:0]           be_s;
  logic [31:0]          st_wdata_s;
  logic                 issue_s;
  logic                 stall_s, wd_s, excp_s;
  logic [31:0]          wdata_s;
  logic [4:0]           addr_s;
  logic                 req_r, we_r;
  logic [DBUS_AW-1:0]   dbus_addr_r;
  logic [3:0]           be_r;
  logic [31:0]          dbus_wdata_r;
  logic [31:0]          rdata_r;
  logic [3:0]           memop_r;
  logic [1:0]           off_r;

  // Lane select plus sign/zero extension of a latched load word.
  function automatic logic [31:0] fmt_load(input logic [3:0] op, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Memop decode into direction and access size.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    size_s     = SZ_W;
    case (ex_memop)
      OP_LB, OP_LBU: begin is_load_s  = 1'b1; size_s = SZ_B; end
      OP_LH, OP_LHU: begin is_load_s  = 1'b1; size_s = SZ_H; end
      OP_LW:         begin is_load_s  = 1'b1; size_s = SZ_W; end
      OP_SB:         begin is_store_s = 1'b1; size_s = SZ_B; end
      OP_SH:         begin is_store_s = 1'b1; size_s = SZ_H; end
      OP_SW:         begin is_store_s = 1'b1; size_s = SZ_W; end
      default:       begin is_load_s  = 1'b0; is_store_s = 1'b0; end
    endcase
  end

`ifdef MEN_ALIGN_CHECK_EN
  // Misaligned half/word accesses are trapped rather than issued.
  always_comb begin
    off_s      = ex_mem_addr[1:0];
    misalign_s = 1'b0;
    if (size_s == SZ_H) begin
      misalign_s = ex_mem_addr[0];
    end else if (size_s == SZ_W) begin
      misalign_s = (ex_mem_addr[1:0] != 2'b00);
    end else begin
      misalign_s = 1'b0;
    end
  end
`else
  // Without trapping, offending low offset bits are dropped.
  always_comb begin
    off_s      = ex_mem_addr[1:0];
    misalign_s = 1'b0;
    if (size_s == SZ_H) begin
      off_s = {ex_mem_addr[1], 1'b0};
    end else if (size_s == SZ_W) begin
      off_s = 2'b00;
    end else begin
      off_s = ex_mem_addr[1:0];
    end
  end
`endif

  // Store byte enables and lane-replicated store data; loads read the whole word.
  always_comb begin
    be_s       = 4'b1111;
    st_wdata_s = 32'h0000_0000;
    if (is_store_s) begin
      case (size_s)
        SZ_B: begin
          be_s       = 4'b0001 << off_s;
          st_wdata_s = {4{ex_store_data[7:0]}};
        end
        SZ_H: begin
          be_s       = 4'b0011 << {off_s[1], 1'b0};
          st_wdata_s = {2{ex_store_data[15:0]}};
        end
        default: begin
          be_s       = 4'b1111;
          st_wdata_s = ex_store_data;
        end
      endcase
    end else begin
      be_s       = 4'b1111;
      st_wdata_s = 32'h0000_0000;
    end
  end

  // Next state and writeback-side outputs; reset forces a bubble.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    stall_s = 1'b0;
    wd_s    = 1'b0;
    excp_s  = 1'b0;
    wdata_s = 32'h0000_0000;
    addr_s  = 5'd0;
    if (rst) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if ((is_load_s || is_store_s) && !misalign_s) begin
            issue_s = 1'b1;
            stall_s = 1'b1;
            state_s = WAIT;
          end else if ((is_load_s || is_store_s) && misalign_s) begin
            excp_s = 1'b1;
          end else begin
            wdata_s = ex_wdata;
            addr_s  = ex_addr;
            wd_s    = ex_wd;
          end
        end
        WAIT: begin
          stall_s = 1'b1;
          if (dbus_ack) begin
            state_s = DONE;
          end else begin
            state_s = WAIT;
          end
        end
        DONE: begin
          addr_s  = ex_addr;
          wd_s    = ex_wd;
          state_s = IDLE;
          if (memop_r >= OP_LB && memop_r <= OP_LW) begin
            wdata_s = fmt_load(memop_r, off_r, rdata_r);
          end else begin
            wdata_s = ex_wdata;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bus request registers, held steady from issue until ack; ack outside WAIT is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      dbus_addr_r  <= '0;
      be_r         <= 4'b0000;
      dbus_wdata_r <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
      memop_r      <= 4'd0;
      off_r        <= 2'b00;
    end else if (issue_s) begin
      req_r        <= 1'b1;
      we_r         <= is_store_s;
      dbus_addr_r  <= {ex_mem_addr[DBUS_AW-1:2], 2'b00};
      be_r         <= be_s;
      dbus_wdata_r <= st_wdata_s;
      memop_r      <= ex_memop;
      off_r        <= off_s;
    end else if (state_r == WAIT && dbus_ack) begin
      req_r   <= 1'b0;
      rdata_r <= dbus_rdata;
    end else begin
      req_r <= req_r;
    end
  end

  assign dbus_req       = req_r;
  assign dbus_we        = we_r;
  assign dbus_addr      = dbus_addr_r;
  assign dbus_be        = be_r;
  assign dbus_wdata     = dbus_wdata_r;
  assign men_wdata      = wdata_s;
  assign men_addr       = addr_s;
  assign men_wd         = wd_s;
  assign stallreq       = stall_s;
  assign men_excp_align = excp_s;

endmodule

// File: tb/tb_men.sv
// Self-checking bench for men: directed cases then randomized memops against a behavioural model.
module tb_men;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_addr;
  logic        ex_wd;
  logic [3:0]  ex_memop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [31:0] men_wdata;
  logic [4:0]  men_addr;
  logic        men_wd;
  logic        stallreq;
  logic        men_excp_align;

  int n_checks = 0;
  int n_errors = 0;

  men #(.DBUS_AW(32)) dut (
    .clk(clk), .rst(rst),
    .ex_wdata(ex_wdata), .ex_addr(ex_addr), .ex_wd(ex_wd), .ex_memop(ex_memop),
    .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .men_wdata(men_wdata), .men_addr(men_addr), .men_wd(men_wd),
    .stallreq(stallreq), .men_excp_align(men_excp_align)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1. nw = WAIT cycles before ack lands.
  task automatic do_op(input logic [3:0] op, input logic [31:0] ma, input logic [31:0] sd,
                       input logic [31:0] wdat, input logic [4:0] ra, input logic wd,
                       input int nw, input logic [31:0] rd);
    bit          ld, st, sgn, mis;
    int          sz;
    logic [1:0]  o;
    logic [3:0]  ebe;
    logic [31:0] ewd, v, eres;
    ld  = (op >= 4'd1 && op <= 4'd5);
    st  = (op >= 4'd6 && op <= 4'd8);
    sz  = (op == 4'd1 || op == 4'd2 || op == 4'd6) ? 1 :
          (op == 4'd3 || op == 4'd4 || op == 4'd7) ? 2 : 4;
    sgn = (op == 4'd1 || op == 4'd3);
    o   = ma[1:0];
    mis = (sz == 2 && o[0]) || (sz == 4 && o != 2'd0);
`ifndef MEN_ALIGN_CHECK_EN
    if (sz == 2) o = o & 2'b10;
    if (sz == 4) o = 2'b00;
    mis = 1'b0;
`endif
    ex_memop = op; ex_mem_addr = ma; ex_store_data = sd;
    ex_wdata = wdat; ex_addr = ra; ex_wd = wd;
    #4;
    if (!ld && !st) begin
      check("pass_wdata", men_wdata, wdat);
      check("pass_addr", 32'(men_addr), 32'(ra));
      check("pass_wd", 32'(men_wd), 32'(wd));
      check("pass_stall", 32'(stallreq), 32'd0);
      check("pass_req", 32'(dbus_req), 32'd0);
      @(posedge clk); #1;
      return;
    end
    if (mis) begin
      check("mis_excp", 32'(men_excp_align), 32'd1);
      check("mis_stall", 32'(stallreq), 32'd0);
      check("mis_wd", 32'(men_wd), 32'd0);
      @(posedge clk); #1;
      check("mis_req", 32'(dbus_req), 32'd0);
      check("mis_excp_gone", 32'(men_excp_align), 32'd0);
      return;
    end
    check("issue_stall", 32'(stallreq), 32'd1);
    check("issue_wd", 32'(men_wd), 32'd0);
    check("issue_excp", 32'(men_excp_align), 32'd0);
    if (ld) ebe = 4'b1111;
    else if (sz == 1) ebe = 4'(1 << o);
    else if (sz == 2) ebe = 4'(3 << o);
    else ebe = 4'b1111;
    if (sz == 1) ewd = {24'd0, sd[7:0]} * 32'h0101_0101;
    else if (sz == 2) ewd = {16'd0, sd[15:0]} * 32'h0001_0001;
    else ewd = sd;
    v = rd >> (8 * o);
    if (sz == 1) begin
      eres = v & 32'h0000_00FF;
      if (sgn && eres[7]) eres = eres | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      eres = v & 32'h0000_FFFF;
      if (sgn && eres[15]) eres = eres | 32'hFFFF_0000;
    end else begin
      eres = rd;
    end
    if (st) eres = wdat;
    for (int i = 0; i < nw; i++) begin
      @(posedge clk); #1;
      if (i == nw - 1) begin dbus_ack = 1'b1; dbus_rdata = rd; end
      else dbus_rdata = $urandom;
      #3;
      check("wait_req", 32'(dbus_req), 32'd1);
      check("wait_we", 32'(dbus_we), 32'(st));
      check("wait_addr", dbus_addr, ma & 32'hFFFF_FFFC);
      check("wait_be", 32'(dbus_be), 32'(ebe));
      if (st) check("wait_wdata", dbus_wdata, ewd);
      check("wait_stall", 32'(stallreq), 32'd1);
      check("wait_wd", 32'(men_wd), 32'd0);
    end
    @(posedge clk); #1;
    dbus_ack = 1'b0; dbus_rdata = $urandom;
    #3;
    check("done_stall", 32'(stallreq), 32'd0);
    check("done_req", 32'(dbus_req), 32'd0);
    check("done_wd", 32'(men_wd), 32'(wd));
    check("done_addr", 32'(men_addr), 32'(ra));
    check("done_wdata", men_wdata, eres);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'd0;
    ex_wdata = 32'h55; ex_addr = 5'd7; ex_wd = 1'b1; ex_memop = 4'd0;
    ex_mem_addr = 32'd0; ex_store_data = 32'd0;
    repeat (2) @(posedge clk);
    #1; #3;
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_we", 32'(dbus_we), 32'd0);
    check("rst_be", 32'(dbus_be), 32'd0);
    check("rst_addr", dbus_addr, 32'd0);
    check("rst_wdata", dbus_wdata, 32'd0);
    check("rst_stall", 32'(stallreq), 32'd0);
    check("rst_wd", 32'(men_wd), 32'd0);
    check("rst_excp", 32'(men_excp_align), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(4'd0, 32'h0, 32'h0, 32'h1234, 5'd3, 1'b1, 1, 32'h0);              // ADD
    do_op(4'd1, 32'h1003, 32'h0, 32'h0, 5'd4, 1'b1, 1, 32'h80FF_FF7F);      // LB
    do_op(4'd4, 32'h2002, 32'h0, 32'h0, 5'd5, 1'b1, 3, 32'hBEEF_0000);      // LHU
    do_op(4'd6, 32'h10, 32'hA5, 32'h99, 5'd0, 1'b0, 2, 32'h0);              // SB
    do_op(4'd7, 32'h12, 32'h1234, 32'h0, 5'd0, 1'b0, 1, 32'h0);             // SH
    do_op(4'd5, 32'h1001, 32'h0, 32'h0, 5'd9, 1'b1, 1, 32'hCAFE_F00D);      // LW misaligned
    do_op(4'd12, 32'h44, 32'h0, 32'hDEAD, 5'd31, 1'b1, 1, 32'h0);           // memop 12 = none

    // Reset while an access is waiting, then a stale ack.
    ex_memop = 4'd1; ex_mem_addr = 32'h40; ex_wd = 1'b1; ex_addr = 5'd6;
    #4 check("rw_issue_stall", 32'(stallreq), 32'd1);
    @(posedge clk); #4;
    check("rw_wait_req", 32'(dbus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dbus_ack = 1'b1; dbus_rdata = 32'h1111_2222;
    ex_memop = 4'd0; ex_wd = 1'b0;
    #3;
    check("rw_req", 32'(dbus_req), 32'd0);
    check("rw_stall", 32'(stallreq), 32'd0);
    check("rw_wd", 32'(men_wd), 32'd0);
    check("rw_be", 32'(dbus_be), 32'd0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    #3;
    check("rw_after_stall", 32'(stallreq), 32'd0);
    check("rw_after_wd", 32'(men_wd), 32'd0);
    check("rw_after_req", 32'(dbus_req), 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(1, 4), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
